digit_scan_mux: RTL and testbench

- Parametrised, time-multiplexed display digit scanner for the memory/display controller path.
- Holds a frame-coherent shadow copy of N digit values, cycles the digit select at a programmable refresh rate, and drives one-hot anodes plus the selected digit value to the 7-segment decoder.
- Inserts an anti-ghosting blank interval between digits and supports per-digit blanking.

---
 rtl/digit_scan_mux_pkg.sv | 12 +
 rtl/digit_scan_mux_scan_timer.sv | 35 +++
 rtl/digit_scan_mux.sv | 67 ++++++
 tb/tb_digit_scan_mux.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_mux_pkg.sv
// digit_scan_mux_pkg: shared scan state encoding and sizing/polarity helpers for the digit scanner.
package digit_scan_mux_pkg;
    localparam int MAX_DIGITS = 64;
    typedef logic [MAX_DIGITS-1:0] an_vec_t;
    typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_state_t;
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
    function automatic an_vec_t an_level(input an_vec_t onehot, input logic active_low);
        return active_low ? ~onehot : onehot;
    endfunction
endpackage

// File: rtl/digit_scan_mux_scan_timer.sv
// digit_scan_mux_scan_timer: slot counter sequencing BLANK/DRIVE phases and flagging the end of each digit slot.
module digit_scan_mux_scan_timer
    import digit_scan_mux_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    output scan_state_t state,
    output scan_state_t state_nxt,
    output logic        advance
);
    localparam int CNT_W = sel_width(TICK_DIV > BLANK_CYC ? TICK_DIV : BLANK_CYC);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);
    // With no blank interval the scan lives permanently in DRIVE.
    localparam scan_state_t FIRST = BLANK_CYC > 0 ? BLANK : DRIVE;
    logic [CNT_W-1:0] cnt;
    logic             blank_done;
    always_comb begin
        blank_done = state == BLANK && cnt == BLANK_LAST;
        advance    = state == DRIVE && cnt == TICK_LAST;
        state_nxt  = blank_done ? DRIVE : (advance && BLANK_CYC > 0) ? BLANK : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FIRST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (blank_done || advance) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed digit scanner with frame-coherent shadow digits,
// anti-ghosting blank interval and per-digit anode enables.
module digit_scan_mux
    import digit_scan_mux_pkg::*;
#(
    parameter  int NUM_DIGITS    = 8,
    parameter  int DATA_W        = 4,
    parameter  int TICK_DIV      = 100000,
    parameter  int BLANK_CYC     = 2,
    parameter  int AN_ACTIVE_LOW = 1,
    localparam int SEL_W         = sel_width(NUM_DIGITS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_DIGITS*DATA_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]        digit_en,
    input  logic                         load,
    output logic [NUM_DIGITS-1:0]        an,
    output logic [DATA_W-1:0]            digit_out,
    output logic [SEL_W-1:0]             sel,
    output logic                         frame_start
);
    localparam logic       POL      = AN_ACTIVE_LOW != 0;
    localparam an_vec_t    AN_OFF   = an_level('0, POL);
    localparam [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);
    scan_state_t                  state, state_nxt;
    logic                         advance, wrap, enter_drive, pend_valid;
    logic [SEL_W-1:0]             sel_nxt;
    logic [NUM_DIGITS*DATA_W-1:0] shadow, pending, shadow_nxt;
    logic [NUM_DIGITS-1:0]        lit;
    an_vec_t                      an_lvl;
    digit_scan_mux_scan_timer #(.TICK_DIV(TICK_DIV), .BLANK_CYC(BLANK_CYC)) timer (
        .clk(clk),
        .reset(reset),
        .state(state),
        .state_nxt(state_nxt),
        .advance(advance)
    );
    // Outputs are computed from next-cycle values so registered outputs line up with the scan state.
    always_comb begin
        wrap        = advance && sel == LAST_SEL;
        sel_nxt     = advance ? (wrap ? '0 : sel + 1'b1) : sel;
        shadow_nxt  = (wrap && load) ? digits_in : (wrap && pend_valid) ? pending : shadow;
        lit         = state_nxt == DRIVE ? (NUM_DIGITS'(1) << sel_nxt) & digit_en : '0;
        an_lvl      = an_level(an_vec_t'(lit), POL);
        enter_drive = state_nxt == DRIVE && (state == BLANK || advance);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sel         <= '0;
            digit_out   <= '0;
            frame_start <= 1'b0;
            an          <= AN_OFF[NUM_DIGITS-1:0];
            shadow      <= '0;
            pending     <= '0;
            pend_valid  <= 1'b0;
        end else begin
            sel         <= sel_nxt;
            digit_out   <= shadow_nxt[int'(sel_nxt)*DATA_W +: DATA_W];
            frame_start <= enter_drive && sel_nxt == '0;
            an          <= an_lvl[NUM_DIGITS-1:0];
            shadow      <= shadow_nxt;
            pending     <= load ? digits_in : pending;
            pend_valid  <= !wrap && (load || pend_valid);
        end
    end
endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: directed scenario bench for the 3-digit, 5-cycle-slot scanner configuration.
module tb_digit_scan_mux;
    logic        clk = 1'b0, reset = 1'b1, load = 1'b0;
    logic [11:0] digits_in = '0;
    logic [2:0]  digit_en = 3'b111;
    logic [2:0]  an;
    logic [3:0]  digit_out;
    logic [1:0]  sel;
    logic        frame_start;
    int passed = 0, total = 0, cyc = 0;

    always #5 clk = ~clk;

    digit_scan_mux #(.NUM_DIGITS(3), .DATA_W(4), .TICK_DIV(4), .BLANK_CYC(1), .AN_ACTIVE_LOW(1)) dut (
        .clk(clk),
        .reset(reset),
        .digits_in(digits_in),
        .digit_en(digit_en),
        .load(load),
        .an(an),
        .digit_out(digit_out),
        .sel(sel),
        .frame_start(frame_start)
    );

    // cyc counts negedges after the first scan edge; slot = 4 DRIVE cycles then 1 BLANK cycle.
    function automatic int exp_sel(input int c);
        return ((c + 1) / 5) % 3;
    endfunction
    function automatic logic drive(input int c);
        return ((c + 1) % 5) != 0;
    endfunction
    function automatic logic [2:0] exp_an(input int c, input logic [2:0] en);
        logic [2:0] oh;
        oh = 3'b001 << exp_sel(c);
        return drive(c) ? ~(oh & en) : 3'b111;
    endfunction
    function automatic logic [3:0] dig(input logic [11:0] s, input int k);
        return s[k*4 +: 4];
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (an !== 3'b111) $display("FAIL reset_an got %b want 111", an); else passed++;
        total++; if (sel !== 2'd0) $display("FAIL reset_sel got %0d want 0", sel); else passed++;
        total++; if (digit_out !== 4'h0) $display("FAIL reset_digit got %h want 0", digit_out); else passed++;
        total++; if (frame_start !== 1'b0) $display("FAIL reset_fs got %b want 0", frame_start); else passed++;
        total++; if (dut.pend_valid !== 1'b0) $display("FAIL reset_pend got %b want 0", dut.pend_valid); else passed++;
        reset = 1'b0;
        digits_in = 12'h321;
        load = 1'b1;
        cyc = -1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_first_frame();
        while (cyc < 14) begin
            total++; if (sel !== 2'(exp_sel(cyc))) $display("FAIL ff_sel c=%0d got %0d want %0d", cyc, sel, exp_sel(cyc)); else passed++;
            total++; if (an !== exp_an(cyc, 3'b111)) $display("FAIL ff_an c=%0d got %b want %b", cyc, an, exp_an(cyc, 3'b111)); else passed++;
            total++; if (digit_out !== 4'h0) $display("FAIL ff_digit c=%0d got %h want 0", cyc, digit_out); else passed++;
            total++; if (frame_start !== (cyc == 0)) $display("FAIL ff_fs c=%0d got %b want %b", cyc, frame_start, cyc == 0); else passed++;
            tick();
        end
    endtask

    task automatic test_commit_scan();
        while (cyc < 21) begin
            total++; if (sel !== 2'(exp_sel(cyc))) $display("FAIL cs_sel c=%0d got %0d want %0d", cyc, sel, exp_sel(cyc)); else passed++;
            total++; if (an !== exp_an(cyc, 3'b111)) $display("FAIL cs_an c=%0d got %b want %b", cyc, an, exp_an(cyc, 3'b111)); else passed++;
            total++; if (digit_out !== dig(12'h321, exp_sel(cyc))) $display("FAIL cs_digit c=%0d got %h want %h", cyc, digit_out, dig(12'h321, exp_sel(cyc))); else passed++;
            tick();
        end
    endtask

    task automatic test_period();
        int fs_seen = 0;
        while (cyc < 51) begin
            total++; if (sel >= 2'd3 || sel !== 2'(exp_sel(cyc))) $display("FAIL per_sel c=%0d got %0d want %0d", cyc, sel, exp_sel(cyc)); else passed++;
            total++; if (frame_start !== (cyc % 15 == 0)) $display("FAIL per_fs c=%0d got %b want %b", cyc, frame_start, cyc % 15 == 0); else passed++;
            total++; if (an !== exp_an(cyc, 3'b111)) $display("FAIL per_an c=%0d got %b want %b", cyc, an, exp_an(cyc, 3'b111)); else passed++;
            if (frame_start === 1'b1) fs_seen++;
            tick();
        end
        total++; if (fs_seen != 2) $display("FAIL per_fs_count got %0d want 2", fs_seen); else passed++;
    endtask

    task automatic test_frame_coherence();
        digits_in = 12'hABC;
        load = 1'b1;
        tick();
        load = 1'b0;
        while (cyc < 56) begin
            total++; if (digit_out !== dig(12'h321, exp_sel(cyc))) $display("FAIL fc_hold c=%0d got %h want %h", cyc, digit_out, dig(12'h321, exp_sel(cyc))); else passed++;
            tick();
        end
        digits_in = 12'hDEF;
        load = 1'b1;
        tick();
        load = 1'b0;
        while (cyc < 59) begin
            total++; if (digit_out !== 4'h3) $display("FAIL fc_late c=%0d got %h want 3", cyc, digit_out); else passed++;
            tick();
        end
        total++; if (dut.pend_valid !== 1'b0) $display("FAIL fc_pend got %b want 0", dut.pend_valid); else passed++;
        while (cyc < 73) begin
            total++; if (digit_out !== dig(12'hDEF, exp_sel(cyc))) $display("FAIL fc_new c=%0d got %h want %h", cyc, digit_out, dig(12'hDEF, exp_sel(cyc))); else passed++;
            tick();
        end
    endtask

    task automatic test_load_on_commit();
        digits_in = 12'h777;
        load = 1'b1;
        tick();
        load = 1'b0;
        total++; if (sel !== 2'd0) $display("FAIL lc_sel got %0d want 0", sel); else passed++;
        total++; if (digit_out !== 4'h7) $display("FAIL lc_digit got %h want 7", digit_out); else passed++;
        total++; if (dut.pend_valid !== 1'b0) $display("FAIL lc_pend got %b want 0", dut.pend_valid); else passed++;
        while (cyc < 80) tick();
        digits_in = 12'h456;
        load = 1'b1;
        tick();
        load = 1'b0;
        while (cyc < 89) begin
            total++; if (digit_out !== 4'h7) $display("FAIL lc_hold c=%0d got %h want 7", cyc, digit_out); else passed++;
            tick();
        end
        total++; if (digit_out !== 4'h6) $display("FAIL lc_next got %h want 6", digit_out); else passed++;
    endtask

    task automatic test_blanking();
        digit_en = 3'b101;
        tick();
        while (cyc < 105) begin
            total++; if (an !== exp_an(cyc, 3'b101)) $display("FAIL bl_an c=%0d got %b want %b", cyc, an, exp_an(cyc, 3'b101)); else passed++;
            total++; if (digit_out !== dig(12'h456, exp_sel(cyc))) $display("FAIL bl_digit c=%0d got %h want %h", cyc, digit_out, dig(12'h456, exp_sel(cyc))); else passed++;
            tick();
        end
        digit_en = 3'b111;
    endtask

    task automatic test_midframe_reset();
        digits_in = 12'h999;
        load = 1'b1;
        tick();
        load = 1'b0;
        while (cyc < 116) tick();
        total++; if (dut.pend_valid !== 1'b1) $display("FAIL mr_prepend got %b want 1", dut.pend_valid); else passed++;
        total++; if (sel !== 2'd2) $display("FAIL mr_presel got %0d want 2", sel); else passed++;
        reset = 1'b1;
        tick();
        total++; if (sel !== 2'd0) $display("FAIL mr_sel got %0d want 0", sel); else passed++;
        total++; if (an !== 3'b111) $display("FAIL mr_an got %b want 111", an); else passed++;
        total++; if (digit_out !== 4'h0) $display("FAIL mr_digit got %h want 0", digit_out); else passed++;
        total++; if (dut.pend_valid !== 1'b0) $display("FAIL mr_pend got %b want 0", dut.pend_valid); else passed++;
        reset = 1'b0;
        cyc = -1;
        tick();
        while (cyc < 30) begin
            total++; if (digit_out !== 4'h0) $display("FAIL mr_after c=%0d got %h want 0", cyc, digit_out); else passed++;
            total++; if (an !== exp_an(cyc, 3'b111)) $display("FAIL mr_an2 c=%0d got %b want %b", cyc, an, exp_an(cyc, 3'b111)); else passed++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_commit_scan();
        test_period();
        test_frame_coherence();
        test_load_on_commit();
        test_blanking();
        test_midframe_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
